llc_set_dispatch: RTL and testbench
===================================

// Module: llc_set_dispatch
// PURPOSE
//  Front-end dispatcher for the LLC set-conflict set table; sits directly upstream of it.
//  Takes one request per cycle into a single hold register and drives the set-table check with that request's set.
//  Issues the request downstream only when its set is not in flight and a table slot is free.
//  Records the set on issue (add) and releases it on completion (remove).
//  The table slot index travels with each request as out_tag.
// PARAMETERS
//  TABLE_SIZE  5   set-table depth; maximum number of requests in flight.
//  SET_W       LLC_SET_BITS   set index width.
//  PAYLOAD_W   64  opaque request payload width.
//  PTR_W       3   table pointer width; requires 2**PTR_W >= TABLE_SIZE.
// PORTS
//  clk                    in   1          clock
//  rst                    in   1          reset, asynchronous, active-low
//  in_valid               in   1          upstream request valid
//  in_ready               out  1          hold register empty
//  in_set                 in   SET_W      request set index
//  in_payload             in   PAYLOAD_W  request payload
//  check_set_table        out  1          set-table lookup enable
//  set_next               out  SET_W      set for lookup and add (hold register set)
//  is_set_in_table        in   1          combinational lookup hit from the table
//  add_set_to_table       out  1          1-cycle pulse: record set_next at set_table_pointer
//  set_table_pointer      in   PTR_W      table's next write slot
//  remove_set_from_table  out  1          1-cycle pulse: free slot table_pointer_to_remove
//  table_pointer_to_remove out PTR_W      slot to free
//  out_valid              out  1          issued request valid
//  out_ready              in   1          downstream accepts
//  out_set                out  SET_W      issued set
//  out_payload            out  PAYLOAD_W  issued payload
//  out_tag                out  PTR_W      table slot owned by the issued request
//  done_valid             in   1          completion pulse from the pipeline
//  done_tag               in   PTR_W      slot of the completing request
//  inflight               out  PTR_W+1    number of issued, uncompleted requests
//  stall_count            out  16         saturating count of blocked cycles
//  err_underflow          out  1          sticky: done_valid seen while inflight==0
// BEHAVIOUR
//  Reset: all registered outputs 0; FSM state IDLE; hold and output registers invalid.
//   in_ready=1 after reset; set_next=0 and out_tag=0 during reset.
//  FSM states (hold register):
//   IDLE -> CHECK when in_valid && in_ready; the edge captures in_set and in_payload.
//   CHECK/STALL: check_set_table=1 and set_next=hold_set (combinational).
//    issue = !is_set_in_table && inflight<TABLE_SIZE && (!out_valid || out_ready).
//    issue=1 -> IDLE.
//    Otherwise -> STALL, and stall_count increments, saturating at 16'hFFFF.
//  in_ready = (state==IDLE); no bypass. Minimum one bubble per request: issue at the earliest
//   1 cycle after capture, new capture 1 cycle after issue.
//   The table update from add is therefore visible before the next lookup.
//  On issue, add_set_to_table=1 for that cycle only.
//   The output register loads hold_set, hold_payload and out_tag=set_table_pointer, and sets out_valid=1.
//  Output register: out_valid stays high, with data stable, until out_valid && out_ready.
//   Issue into the register is allowed in the same cycle as its drain.
//  remove_set_from_table=done_valid; table_pointer_to_remove=done_tag (combinational pass-through).
//   Exception: a done_valid while inflight==0 is suppressed, and err_underflow is set sticky.
//  inflight += add, -= accepted remove. Add and remove in the same cycle leave it unchanged.
//   It never exceeds TABLE_SIZE, because issue is blocked at TABLE_SIZE.
//  Same-cycle remove of the blocking set: the table reflects the remove next cycle, so the issue
//   happens at the earliest one cycle after done_valid.
//  check_set_table=0 in IDLE. set_next is held at the last hold_set, so a stray table write is harmless.
//  Reset mid-operation: hold and output contents are discarded, and no add/remove pulse is emitted.
// TESTING
//  T1: set 0x12 into an empty table -> out_valid 2 cycles after in_valid; add pulse 1 cycle; out_tag=0; inflight=1.
//  T2: table holds 0x12; new request 0x12 -> STALL, stall_count counts.
//   Then done_valid, tag 0 -> issue 1 cycle later; inflight unchanged over the done/issue pair.
//  T3: 5 distinct sets 0x1..0x5 issued with out_ready=1, then a 6th (0x6) -> blocked at inflight=5.
//   Then done_tag=2 -> 0x6 issues with out_tag=0 (pointer wrap).
//  T4: out_ready=0 with two non-conflicting requests -> first holds in the output register.
//   The second stays in the hold register, with no second add, until out_ready rises; in_ready=0 meanwhile.
//  T5: done_valid at inflight=0 -> no remove pulse; err_underflow=1 until reset.
//  T6: rst low while in STALL with out_valid=1 -> out_valid=0, in_ready=1 and stall_count=0 on release.

Source files
------------

// File: rtl/llc_set_dispatch_if.sv
// ============================================================================
// Module      : llc_set_dispatch_if
// Description : Request, set-table, issue and completion signals of the
//               LLC set-conflict dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface llc_set_dispatch_if #(
    parameter int SET_W     = 10,
    parameter int PAYLOAD_W = 64,
    parameter int PTR_W     = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [SET_W-1:0]     in_set;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 check_set_table;
    logic [SET_W-1:0]     set_next;
    logic                 is_set_in_table;
    logic                 add_set_to_table;
    logic [PTR_W-1:0]     set_table_pointer;
    logic                 remove_set_from_table;
    logic [PTR_W-1:0]     table_pointer_to_remove;

    logic                 out_valid;
    logic                 out_ready;
    logic [SET_W-1:0]     out_set;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [PTR_W-1:0]     out_tag;

    logic                 done_valid;
    logic [PTR_W-1:0]     done_tag;

    logic [PTR_W:0]       inflight;
    logic [15:0]          stall_count;
    logic                 err_underflow;

    // Dispatcher side
    modport master (
        input  in_valid, in_set, in_payload,
        input  is_set_in_table, set_table_pointer,
        input  out_ready, done_valid, done_tag,
        output in_ready, check_set_table, set_next, add_set_to_table,
        output remove_set_from_table, table_pointer_to_remove,
        output out_valid, out_set, out_payload, out_tag,
        output inflight, stall_count, err_underflow
    );

    // Environment side: upstream, set table, downstream and pipeline
    modport slave (
        output in_valid, in_set, in_payload,
        output is_set_in_table, set_table_pointer,
        output out_ready, done_valid, done_tag,
        input  in_ready, check_set_table, set_next, add_set_to_table,
        input  remove_set_from_table, table_pointer_to_remove,
        input  out_valid, out_set, out_payload, out_tag,
        input  inflight, stall_count, err_underflow
    );
endinterface

`default_nettype wire

// File: rtl/llc_set_dispatch.sv
// ============================================================================
// Module      : llc_set_dispatch
// Description : Front-end dispatcher for the LLC set-conflict set table.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module llc_set_dispatch #(
    parameter int TABLE_SIZE = 5,
    parameter int SET_W      = 10,
    parameter int PAYLOAD_W  = 64,
    parameter int PTR_W      = 3
) (
    input  wire                  clk,
    input  wire                  rst,
    llc_set_dispatch_if.master   bus
);
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_check = 2'd1;
    localparam logic [1:0] c_st_stall = 2'd2;

    localparam logic [PTR_W:0] c_table_size = (PTR_W+1)'(TABLE_SIZE);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [SET_W-1:0]     r_hold_set;
    logic [PAYLOAD_W-1:0] r_hold_payload;
    logic                 r_out_valid;
    logic [SET_W-1:0]     r_out_set;
    logic [PAYLOAD_W-1:0] r_out_payload;
    logic [PTR_W-1:0]     r_out_tag;
    logic [PTR_W:0]       r_inflight;
    logic [15:0]          r_stall_count;
    logic                 r_err_underflow;

    logic w_can_issue;
    logic w_issue;
    logic w_check;
    logic w_in_ready;
    logic w_remove;
    logic w_capture;

    assign w_can_issue = !bus.is_set_in_table && (r_inflight < c_table_size) &&
                         (!r_out_valid || bus.out_ready);
    assign w_capture   = w_in_ready && bus.in_valid;
    // A completion with nothing in flight is never forwarded to the table
    assign w_remove    = bus.done_valid && (r_inflight != '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:              w_state_next = bus.in_valid ? c_st_check : c_st_idle;
            c_st_check, c_st_stall: w_state_next = w_can_issue ? c_st_idle : c_st_stall;
            default:                w_state_next = c_st_idle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_in_ready = 1'b0;
        w_check    = 1'b0;
        w_issue    = 1'b0;
        case (r_state)
            c_st_idle: w_in_ready = 1'b1;
            c_st_check, c_st_stall: begin
                w_check = 1'b1;
                w_issue = w_can_issue;
            end
            default: w_in_ready = 1'b0;
        endcase
    end

    // Hold register only loads on capture, so set_next keeps the last set in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_set     <= '0;
            r_hold_payload <= '0;
        end else if (w_capture) begin
            r_hold_set     <= bus.in_set;
            r_hold_payload <= bus.in_payload;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid   <= 1'b0;
            r_out_set     <= '0;
            r_out_payload <= '0;
            r_out_tag     <= '0;
        end else if (w_issue) begin
            r_out_valid   <= 1'b1;
            r_out_set     <= r_hold_set;
            r_out_payload <= r_hold_payload;
            r_out_tag     <= bus.set_table_pointer;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight      <= '0;
            r_stall_count   <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            case ({w_issue, w_remove})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            if (w_check && !w_issue && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (bus.done_valid && (r_inflight == '0)) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign bus.in_ready                = w_in_ready;
    assign bus.check_set_table         = w_check;
    assign bus.set_next                = r_hold_set;
    assign bus.add_set_to_table        = w_issue;
    assign bus.remove_set_from_table   = w_remove;
    assign bus.table_pointer_to_remove = bus.done_tag;
    assign bus.out_valid               = r_out_valid;
    assign bus.out_set                 = r_out_set;
    assign bus.out_payload             = r_out_payload;
    assign bus.out_tag                 = r_out_tag;
    assign bus.inflight                = r_inflight;
    assign bus.stall_count             = r_stall_count;
    assign bus.err_underflow           = r_err_underflow;

endmodule

`default_nettype wire

// File: tb/tb_llc_set_dispatch.sv
// ============================================================================
// Module      : tb_llc_set_dispatch
// Description : Directed self-checking bench for llc_set_dispatch with a
//               behavioural set table attached.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_llc_set_dispatch;
    localparam int TABLE_SIZE = 5;
    localparam int SET_W      = 10;
    localparam int PAYLOAD_W  = 64;
    localparam int PTR_W      = 3;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    llc_set_dispatch_if #(.SET_W(SET_W), .PAYLOAD_W(PAYLOAD_W), .PTR_W(PTR_W)) bus ();

    llc_set_dispatch #(
        .TABLE_SIZE (TABLE_SIZE),
        .SET_W      (SET_W),
        .PAYLOAD_W  (PAYLOAD_W),
        .PTR_W      (PTR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Set table: registered add/remove, combinational lookup, circular write pointer
    logic [SET_W-1:0]      tbl_set [TABLE_SIZE];
    logic [TABLE_SIZE-1:0] tbl_vld;
    logic [PTR_W-1:0]      tbl_ptr;
    logic                  tbl_hit;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_vld <= '0;
            tbl_ptr <= '0;
        end else begin
            if (bus.remove_set_from_table)
                tbl_vld[bus.table_pointer_to_remove] <= 1'b0;
            if (bus.add_set_to_table) begin
                tbl_set[tbl_ptr] <= bus.set_next;
                tbl_vld[tbl_ptr] <= 1'b1;
                tbl_ptr <= (tbl_ptr == PTR_W'(TABLE_SIZE - 1)) ? '0 : tbl_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        tbl_hit = 1'b0;
        for (int i = 0; i < TABLE_SIZE; i++)
            if (tbl_vld[i] && (tbl_set[i] == bus.set_next)) tbl_hit = 1'b1;
    end

    assign bus.is_set_in_table   = bus.check_set_table && tbl_hit;
    assign bus.set_table_pointer = tbl_ptr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request in an IDLE cycle; returns just after the capture edge
    task automatic send(input logic [SET_W-1:0] s, input logic [PAYLOAD_W-1:0] p);
        bus.in_valid   = 1'b1;
        bus.in_set     = s;
        bus.in_payload = p;
        step();
        bus.in_valid   = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.done_valid = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        rst            = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_set     = '0;
        bus.in_payload = '0;
        bus.out_ready  = 1'b1;
        bus.done_valid = 1'b0;
        bus.done_tag   = '0;
        step();
        step();
        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_set_next",  bus.set_next, 0);
        chk("rst_out_tag",   bus.out_tag, 0);
        chk("rst_inflight",  bus.inflight, 0);
        chk("rst_stall",     bus.stall_count, 0);
        chk("rst_err",       bus.err_underflow, 0);
        chk("rst_check",     bus.check_set_table, 0);
        rst = 1'b1;
        step();

        // T1: single request into an empty table
        bus.in_valid = 1'b1; bus.in_set = 10'h12; bus.in_payload = 64'hA1A1_0000_0000_0001;
        #1;
        chk("t1_in_ready", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        #1;
        chk("t1_check",    bus.check_set_table, 1);
        chk("t1_set_next", bus.set_next, 10'h12);
        chk("t1_add",      bus.add_set_to_table, 1);
        chk("t1_ov_early", bus.out_valid, 0);
        step(); #1;
        chk("t1_out_valid", bus.out_valid, 1);
        chk("t1_out_set",   bus.out_set, 10'h12);
        chk("t1_out_pay",   bus.out_payload, 64'hA1A1_0000_0000_0001);
        chk("t1_out_tag",   bus.out_tag, 0);
        chk("t1_inflight",  bus.inflight, 1);
        chk("t1_add_once",  bus.add_set_to_table, 0);
        chk("t1_in_ready2", bus.in_ready, 1);
        step(); #1;
        chk("t1_drained", bus.out_valid, 0);

        // T2: conflicting set stalls until its slot is released
        send(10'h12, 64'hB2B2_0000_0000_0002); #1;
        chk("t2_hit",    bus.is_set_in_table, 1);
        chk("t2_no_add", bus.add_set_to_table, 0);
        step(); #1;
        chk("t2_stall1", bus.stall_count, 1);
        step(); #1;
        chk("t2_stall2",    bus.stall_count, 2);
        chk("t2_in_ready0", bus.in_ready, 0);
        bus.done_valid = 1'b1; bus.done_tag = 3'd0;
        #1;
        chk("t2_remove",     bus.remove_set_from_table, 1);
        chk("t2_remove_ptr", bus.table_pointer_to_remove, 0);
        chk("t2_no_add2",    bus.add_set_to_table, 0);
        step();
        bus.done_valid = 1'b0;
        #1;
        chk("t2_add",       bus.add_set_to_table, 1);
        chk("t2_infl_mid",  bus.inflight, 0);
        chk("t2_stall3",    bus.stall_count, 3);
        step(); #1;
        chk("t2_out_valid", bus.out_valid, 1);
        chk("t2_out_set",   bus.out_set, 10'h12);
        chk("t2_out_pay",   bus.out_payload, 64'hB2B2_0000_0000_0002);
        chk("t2_out_tag",   bus.out_tag, 1);
        chk("t2_inflight",  bus.inflight, 1);
        chk("t2_stall_hold", bus.stall_count, 3);

        // T3: fill the table, block the sixth, release slot 2, pointer wraps
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            send(SET_W'(i), 64'(i));
            step();
        end
        #1;
        chk("t3_full",     bus.inflight, 5);
        chk("t3_ptr_wrap", bus.set_table_pointer, 0);
        send(10'h6, 64'h6666); #1;
        chk("t3_no_hit",  bus.is_set_in_table, 0);
        chk("t3_blocked", bus.add_set_to_table, 0);
        step(); step(); #1;
        chk("t3_stall2",   bus.stall_count, 2);
        chk("t3_in_ready", bus.in_ready, 0);
        chk("t3_blocked2", bus.add_set_to_table, 0);
        chk("t3_full2",    bus.inflight, 5);
        bus.done_valid = 1'b1; bus.done_tag = 3'd2;
        #1;
        chk("t3_remove",     bus.remove_set_from_table, 1);
        chk("t3_remove_ptr", bus.table_pointer_to_remove, 2);
        step();
        bus.done_valid = 1'b0;
        #1;
        chk("t3_infl4",  bus.inflight, 4);
        chk("t3_add",    bus.add_set_to_table, 1);
        chk("t3_stall3", bus.stall_count, 3);
        step(); #1;
        chk("t3_out_tag", bus.out_tag, 0);
        chk("t3_out_set", bus.out_set, 10'h6);
        chk("t3_infl5",   bus.inflight, 5);

        // T4: downstream back-pressure holds the second request
        do_reset();
        bus.out_ready = 1'b0;
        send(10'h21, 64'hAAAA); step(); #1;
        chk("t4_ov_a",  bus.out_valid, 1);
        chk("t4_set_a", bus.out_set, 10'h21);
        send(10'h22, 64'hBBBB); #1;
        chk("t4_no_add", bus.add_set_to_table, 0);
        step(); step(); #1;
        chk("t4_no_add2",   bus.add_set_to_table, 0);
        chk("t4_in_ready0", bus.in_ready, 0);
        chk("t4_set_hold",  bus.out_set, 10'h21);
        chk("t4_pay_hold",  bus.out_payload, 64'hAAAA);
        chk("t4_infl1",     bus.inflight, 1);
        bus.out_ready = 1'b1;
        #1;
        chk("t4_add_drain", bus.add_set_to_table, 1);
        step(); #1;
        chk("t4_ov_b",  bus.out_valid, 1);
        chk("t4_set_b", bus.out_set, 10'h22);
        chk("t4_tag_b", bus.out_tag, 1);
        chk("t4_infl2", bus.inflight, 2);
        chk("t4_in_ready1", bus.in_ready, 1);

        // T5: completion with nothing in flight
        do_reset();
        chk("t5_err0", bus.err_underflow, 0);
        bus.done_valid = 1'b1; bus.done_tag = 3'd3;
        #1;
        chk("t5_no_remove", bus.remove_set_from_table, 0);
        step();
        bus.done_valid = 1'b0;
        #1;
        chk("t5_err1",  bus.err_underflow, 1);
        chk("t5_infl0", bus.inflight, 0);
        step(); step(); #1;
        chk("t5_err_sticky", bus.err_underflow, 1);

        // T6: reset asserted while stalled with a held output
        bus.out_ready = 1'b0;
        send(10'h31, 64'h3131); step();
        send(10'h32, 64'h3232); step(); step(); #1;
        chk("t6_ov",       bus.out_valid, 1);
        chk("t6_in_ready", bus.in_ready, 0);
        chk("t6_stall",    bus.stall_count, 2);
        rst = 1'b0;
        #1;
        chk("t6_rst_ov",    bus.out_valid, 0);
        chk("t6_rst_rdy",   bus.in_ready, 1);
        chk("t6_rst_stall", bus.stall_count, 0);
        chk("t6_rst_add",   bus.add_set_to_table, 0);
        step();
        rst = 1'b1;
        #1;
        chk("t6_rel_ov",    bus.out_valid, 0);
        chk("t6_rel_rdy",   bus.in_ready, 1);
        chk("t6_rel_stall", bus.stall_count, 0);
        chk("t6_rel_err",   bus.err_underflow, 0);
        chk("t6_rel_infl",  bus.inflight, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
